// File: rtl/mul16_seq_if.sv
// Handshake and result bundle between control/writeback logic and the
// iterative multiplier.
interface mul16_seq_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             valid;
    logic [WIDTH-1:0] p_lo;
    logic [WIDTH-1:0] p_hi;

    modport master (
        output start, a, b,
        input  busy, done, valid, p_lo, p_hi
    );

    modport slave (
        input  start, a, b,
        output busy, done, valid, p_lo, p_hi
    );
endinterface

// File: rtl/mul16_seq.sv
// Iterative unsigned shift-add multiplier with a fixed WIDTH-cycle latency.
// valid steers p_lo through the downstream writeback mux.
module mul16_seq #(
    parameter int WIDTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    mul16_seq_if.slave   bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int PW    = 2 * WIDTH;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             state_r, state_s;
    logic [PW-1:0]      mcand_r, mcand_s;
    logic [WIDTH-1:0]   mplier_r, mplier_s;
    logic [PW-1:0]      acc_r, acc_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic               busy_r, busy_s;
    logic               done_r, done_s;
    logic               valid_r, valid_s;
    logic [WIDTH-1:0]   p_lo_r, p_lo_s;
    logic [WIDTH-1:0]   p_hi_r, p_hi_s;
    logic [PW-1:0]      sum_s;

    // Accumulator value after this cycle's conditional partial-product add.
    always_comb begin
        if (mplier_r[0]) begin
            sum_s = acc_r + mcand_r;
        end else begin
            sum_s = acc_r;
        end
    end

    // Next-state and next-output logic for the IDLE/RUN sequencer.
    always_comb begin
        state_s  = state_r;
        mcand_s  = mcand_r;
        mplier_s = mplier_r;
        acc_s    = acc_r;
        cnt_s    = cnt_r;
        busy_s   = busy_r;
        done_s   = 1'b0;
        valid_s  = valid_r;
        p_lo_s   = p_lo_r;
        p_hi_s   = p_hi_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    mcand_s  = {{WIDTH{1'b0}}, bus.a};
                    mplier_s = bus.b;
                    acc_s    = {PW{1'b0}};
                    cnt_s    = {CNT_W{1'b0}};
                    busy_s   = 1'b1;
                    valid_s  = 1'b0;
                    state_s  = ST_RUN;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_RUN: begin
                acc_s    = sum_s;
                mcand_s  = {mcand_r[PW-2:0], 1'b0};
                mplier_s = {1'b0, mplier_r[WIDTH-1:1]};
                cnt_s    = cnt_r + CNT_W'(1);
                // The last iteration publishes the sum including its own add.
                if (cnt_r == CNT_W'(WIDTH - 1)) begin
                    p_hi_s  = sum_s[PW-1:WIDTH];
                    p_lo_s  = sum_s[WIDTH-1:0];
                    done_s  = 1'b1;
                    valid_s = 1'b1;
                    busy_s  = 1'b0;
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            default: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
                valid_s = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            mcand_r  <= {PW{1'b0}};
            mplier_r <= {WIDTH{1'b0}};
            acc_r    <= {PW{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            valid_r  <= 1'b0;
            p_lo_r   <= {WIDTH{1'b0}};
            p_hi_r   <= {WIDTH{1'b0}};
        end else begin
            state_r  <= state_s;
            mcand_r  <= mcand_s;
            mplier_r <= mplier_s;
            acc_r    <= acc_s;
            cnt_r    <= cnt_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
            valid_r  <= valid_s;
            p_lo_r   <= p_lo_s;
            p_hi_r   <= p_hi_s;
        end
    end

    assign bus.busy  = busy_r;
    assign bus.done  = done_r;
    assign bus.valid = valid_r;
    assign bus.p_lo  = p_lo_r;
    assign bus.p_hi  = p_hi_r;
endmodule

// File: tb/tb_mul16_seq.sv
// Directed bench for mul16_seq: latency, products, ignored START, async reset
// and back-to-back start in the DONE cycle.
module tb_mul16_seq;
    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    mul16_seq_if #(.WIDTH(16)) bus ();

    mul16_seq #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance n edges while an operation is in flight.
    task automatic run_edges(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            step();
            chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
            chk({tag, "_done"}, {31'd0, bus.done}, 32'd0);
            chk({tag, "_valid"}, {31'd0, bus.valid}, 32'd0);
        end
    endtask

    task automatic start_op(input logic [15:0] a, input logic [15:0] b);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        step();
        bus.start = 1'b0;
        bus.a     = 16'hDEAD;
        bus.b     = 16'hBEEF;
    endtask

    // Completion edge: one DONE pulse with the expected product.
    task automatic final_check(input logic [15:0] hi, input logic [15:0] lo, input string tag);
        step();
        chk({tag, "_done"}, {31'd0, bus.done}, 32'd1);
        chk({tag, "_valid"}, {31'd0, bus.valid}, 32'd1);
        chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
        chk({tag, "_p_hi"}, {16'd0, bus.p_hi}, {16'd0, hi});
        chk({tag, "_p_lo"}, {16'd0, bus.p_lo}, {16'd0, lo});
        step();
        chk({tag, "_done_pulse"}, {31'd0, bus.done}, 32'd0);
        chk({tag, "_valid_hold"}, {31'd0, bus.valid}, 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = 16'h0000;
        bus.b     = 16'h0000;
        step();
        step();
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_valid", {31'd0, bus.valid}, 32'd0);
        chk("rst_p", {bus.p_hi, bus.p_lo}, 32'h0000_0000);
        rst = 1'b0;
        step();

        // 3 * 5
        start_op(16'd3, 16'd5);
        run_edges(15, "t1");
        final_check(16'h0000, 16'h000F, "t1");

        // 0xFFFF * 0xFFFF, result then held while idle
        start_op(16'hFFFF, 16'hFFFF);
        run_edges(15, "t2");
        final_check(16'hFFFE, 16'h0001, "t2");
        for (int i = 0; i < 5; i++) step();
        chk("t2_idle_valid", {31'd0, bus.valid}, 32'd1);
        chk("t2_idle_p", {bus.p_hi, bus.p_lo}, 32'hFFFE_0001);

        // zero multiplier keeps the full latency
        start_op(16'h1234, 16'h0000);
        chk("t3_stale_p", {bus.p_hi, bus.p_lo}, 32'hFFFE_0001);
        run_edges(15, "t3");
        final_check(16'h0000, 16'h0000, "t3");

        // START while busy is ignored
        start_op(16'd2, 16'd7);
        run_edges(4, "t4a");
        bus.start = 1'b1;
        bus.a     = 16'd9;
        bus.b     = 16'd9;
        run_edges(1, "t4b");
        bus.start = 1'b0;
        run_edges(10, "t4c");
        final_check(16'h0000, 16'h000E, "t4");
        for (int i = 0; i < 20; i++) begin
            step();
            chk("t4_no_2nd_done", {31'd0, bus.done}, 32'd0);
        end
        chk("t4_hold_p", {bus.p_hi, bus.p_lo}, 32'h0000_000E);

        // asynchronous reset mid-operation
        start_op(16'h00FF, 16'h0100);
        run_edges(7, "t5");
        chk("t5_stale_p_lo", {16'd0, bus.p_lo}, 32'h0000_000E);
        #3;
        rst = 1'b1;
        #1;
        chk("t5_async_busy", {31'd0, bus.busy}, 32'd0);
        chk("t5_async_valid", {31'd0, bus.valid}, 32'd0);
        chk("t5_async_done", {31'd0, bus.done}, 32'd0);
        chk("t5_async_p", {bus.p_hi, bus.p_lo}, 32'h0000_0000);
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("t5_idle_done", {31'd0, bus.done}, 32'd0);
            chk("t5_idle_busy", {31'd0, bus.busy}, 32'd0);
        end
        start_op(16'd4, 16'd4);
        run_edges(15, "t5n");
        final_check(16'h0000, 16'h0010, "t5n");

        // back-to-back: START presented during the DONE cycle
        start_op(16'd3, 16'd5);
        run_edges(15, "t6a");
        step();
        chk("t6_done", {31'd0, bus.done}, 32'd1);
        chk("t6_p_lo", {16'd0, bus.p_lo}, 32'h0000_000F);
        start_op(16'h0100, 16'h0100);
        chk("t6_valid_drop", {31'd0, bus.valid}, 32'd0);
        chk("t6_done_drop", {31'd0, bus.done}, 32'd0);
        chk("t6_busy", {31'd0, bus.busy}, 32'd1);
        chk("t6_p_lo_hold", {16'd0, bus.p_lo}, 32'h0000_000F);
        run_edges(15, "t6b");
        final_check(16'h0001, 16'h0000, "t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/mul16_seq.md
Name: mul16_seq

Overview:
- Iterative 16x16 unsigned shift-add multiplier in the 16-bit datapath.
- Sits directly upstream of the 16-bit 2:1 result mux. P_LO drives the mux's D2 input; the ALU result drives D1.
- VALID drives the mux select S1, so the product is steered to writeback only while a completed result is held.
- Start/busy/done handshake with fixed latency, so control can schedule it deterministically.

Parameters:
- WIDTH, 16, operand width. The product is 2*WIDTH bits, split into P_HI and P_LO.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- START  input  1  request a multiply; sampled only in IDLE.
- A  input  WIDTH  multiplicand; captured on the accepting edge.
- B  input  WIDTH  multiplier; captured on the accepting edge.
- BUSY  output  1  high while an operation is in progress.
- DONE  output  1  one-cycle pulse when the result registers update.
- VALID  output  1  result held and valid; feeds mux S1.
- P_LO  output  WIDTH  low half of the product; feeds mux D2.
- P_HI  output  WIDTH  high half of the product.

Behaviour:
- Reset: RST high asynchronously forces state IDLE and clears all outputs: BUSY=0, DONE=0, VALID=0, P_LO=0, P_HI=0. Internal accumulator, shift registers and counter are also cleared. This applies mid-operation too: the partial result is discarded and no DONE is produced.
- States: IDLE, RUN.
- IDLE + START=1 at an edge:
  - mcand <= {WIDTH zeros, A} (2*WIDTH bits); mplier <= B; acc <= 0; cnt <= 0.
  - BUSY <= 1; VALID <= 0; state <= RUN.
- IDLE + START=0: hold all registers. VALID and P_* keep their last values.
- RUN, each edge:
  - If mplier[0]=1, acc <= acc + mcand (2*WIDTH-bit add; no overflow is possible).
  - mcand <= mcand << 1; mplier <= mplier >> 1; cnt <= cnt + 1.
- RUN edge with cnt = WIDTH-1 (the WIDTH-th RUN edge):
  - {P_HI,P_LO} <= final sum, including this edge's conditional add.
  - DONE <= 1 for exactly one cycle; VALID <= 1; BUSY <= 0; state <= IDLE.
- Latency: START accepted at edge 0, DONE/VALID/P_* update at edge WIDTH (16). Latency is fixed and independent of operand values, including zero.
- START while BUSY: ignored. Operands are not re-sampled and the cycle count is unchanged.
- Back-to-back: START high during the DONE cycle is accepted, since the state is already IDLE. At that edge VALID drops and P_* hold the old value until the new completion. DONE deasserts at that edge as normal.
- P_HI/P_LO change only at completion or reset. They hold the stale result while BUSY, with VALID=0.
- A and B may change after the accepting edge without affecting the result.
- cnt is sized to ceil(log2(WIDTH)) bits minimum. It does not wrap because the state exits at WIDTH-1.

Test Plan:
- Reset release, A=3, B=5, START pulse at edge 0 -> BUSY=1 on edges 1..15; at edge 16: DONE=1 for one cycle, VALID=1, P_HI=0x0000, P_LO=0x000F.
- A=0xFFFF, B=0xFFFF -> after 16 cycles P_HI=0xFFFE, P_LO=0x0001, VALID stays 1 until the next START.
- A=0x1234, B=0 -> still 16-cycle latency; P_HI=P_LO=0x0000, DONE pulses.
- Start A=2, B=7; at edge 5 drive START=1 with A=9, B=9 -> ignored; result P_LO=0x000E at edge 16, and no second DONE.
- Start A=0x00FF, B=0x0100; assert RST at cycle 8 -> all outputs 0 immediately, without waiting for a clock edge. After release, IDLE with no DONE. A new START with A=4, B=4 gives P_LO=0x0010 16 cycles later.
- Complete 3*5, then hold START=1 in the DONE cycle with A=0x0100, B=0x0100 -> VALID drops at that edge and P_LO stays 0x000F. 16 cycles later P_HI=0x0001, P_LO=0x0000, VALID=1.
